// File: rtl/receptor_imagen_uart_pkg.sv
// receptor_imagen_uart_pkg: image-selection codes and receiver state encoding shared with the keypad transmitter
package receptor_imagen_uart_pkg;
    localparam logic [7:0] COD_NINGUNA = 8'h00;
    localparam logic [7:0] COD_IMG1    = 8'h01;
    localparam logic [7:0] COD_IMG2    = 8'h02;
    localparam logic [7:0] COD_IMG3    = 8'h03;

    typedef enum logic [2:0] {IDLE, INICIO, DATOS, PARADA, ESPERA_ALTO} estado_t;

    function automatic logic es_codigo(input logic [7:0] b);
        return b <= COD_IMG3;
    endfunction
endpackage

// File: rtl/receptor_imagen_uart_generador_ticks_baud.sv
// generador_ticks_baud: free-running one-clk strobe at OVERSAMPLE times the baud rate
module generador_ticks_baud #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int W   = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/receptor_imagen_uart.sv
// receptor_imagen_uart: 16x-oversampled 8N1 receiver decoding image-selection codes into a registered index
module receptor_imagen_uart
    import receptor_imagen_uart_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       dato_listo,
    output logic [1:0] imagen_sel,
    output logic       imagen_nueva,
    output logic       error_trama,
    output logic       codigo_invalido
);
    logic       rx_m, rx_s, tick;
    estado_t    estado;
    logic [3:0] os;
    logic [2:0] n;
    logic [7:0] sr;

    generador_ticks_baud #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) u_ticks (
        .clk(clk), .reset(reset), .tick(tick)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_m, rx_s} <= 2'b11;
        else       {rx_m, rx_s} <= {rx, rx_m};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= IDLE;
            os              <= '0;
            n               <= '0;
            sr              <= '0;
            dato            <= '0;
            dato_listo      <= 1'b0;
            imagen_sel      <= '0;
            imagen_nueva    <= 1'b0;
            error_trama     <= 1'b0;
            codigo_invalido <= 1'b0;
        end else begin
            dato_listo      <= 1'b0;
            imagen_nueva    <= 1'b0;
            error_trama     <= 1'b0;
            codigo_invalido <= 1'b0;
            case (estado)
                IDLE: if (!rx_s) begin
                    os     <= '0;
                    estado <= INICIO;
                end
                INICIO: if (tick) begin
                    os <= os + 4'd1;
                    if (os == 4'd7) begin
                        if (!rx_s) begin
                            os     <= '0;
                            n      <= '0;
                            estado <= DATOS;
                        end else estado <= IDLE;
                    end
                end
                // os wraps 15 -> 0 on the sampling tick, so PARADA starts a fresh bit period
                DATOS: if (tick) begin
                    os <= os + 4'd1;
                    if (os == 4'd15) begin
                        sr <= {rx_s, sr[7:1]};
                        n  <= n + 3'd1;
                        if (n == 3'd7) estado <= PARADA;
                    end
                end
                PARADA: if (tick) begin
                    os <= os + 4'd1;
                    if (os == 4'd15) begin
                        if (rx_s) begin
                            dato       <= sr;
                            dato_listo <= 1'b1;
                            if (es_codigo(sr)) begin
                                imagen_sel   <= sr[1:0];
                                imagen_nueva <= 1'b1;
                            end else codigo_invalido <= 1'b1;
                            estado <= IDLE;
                        end else begin
                            error_trama <= 1'b1;
                            estado      <= ESPERA_ALTO;
                        end
                    end
                end
                ESPERA_ALTO: if (rx_s) estado <= IDLE;
                default: estado <= IDLE;
            endcase
        end
    end
endmodule
